// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, bus-cycle kinds and
// the strobe decoder used when the responder is idle.
package z80_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAITST, ACCESS, HOLD} rsp_state_t;

  typedef enum logic [2:0] {CYC_MRD, CYC_MWR, CYC_IORD, CYC_IOWR, CYC_INTA} cyc_t;

  typedef struct packed {
    logic valid;
    cyc_t cyc;
  } cyc_dec_t;

  localparam int WAIT_CNT_W = 8;

  // INTA outranks everything; refresh never qualifies as a memory access
  function automatic cyc_dec_t classify(input logic n_m1, input logic n_mreq,
                                        input logic n_iorq, input logic n_rd,
                                        input logic n_wr, input logic n_rfsh);
    cyc_dec_t d;
    d.valid = 1'b1;
    d.cyc   = CYC_MRD;
    if (!n_iorq && !n_m1)                d.cyc = CYC_INTA;
    else if (!n_mreq && n_rfsh && !n_rd) d.cyc = CYC_MRD;
    else if (!n_mreq && n_rfsh && !n_wr) d.cyc = CYC_MWR;
    else if (!n_iorq && n_m1 && !n_rd)   d.cyc = CYC_IORD;
    else if (!n_iorq && n_m1 && !n_wr)   d.cyc = CYC_IOWR;
    else                                 d.valid = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/z80_resp_ram.sv
// Single-port byte RAM with registered read, backing the responder's
// memory space. Contents are never reset.
module z80_resp_ram #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/z80_bus_responder_n.sv
// Target-side responder for the active-low Z80 pin interface: RAM, IO bank,
// interrupt request and INTA vector, with programmable wait states.
//
// state  | meaning
// IDLE   | bus idle, classify strobes and latch cycle type/address
// WAITST | nWAIT held low while the wait counter runs down
// ACCESS | single cycle doing the read capture or the write
// HOLD   | keep read data on the bus until nMREQ and nIORQ both rise
module z80_bus_responder_n
  import z80_bus_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int IO_PORTS    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [15:0]           A,
  input  logic [7:0]            D_in,
  output logic [7:0]            D_out,
  output logic                  D_oe,
  input  logic                  nM1,
  input  logic                  nMREQ,
  input  logic                  nIORQ,
  input  logic                  nRD,
  input  logic                  nWR,
  input  logic                  nRFSH,
  output logic                  nWAIT,
  output logic                  nINT,
  input  logic                  int_req,
  input  logic [7:0]            int_vector,
  output logic [8*IO_PORTS-1:0] io_out
);

  localparam int IO_AW = $clog2(IO_PORTS);

  rsp_state_t            r_state, w_state_nx;
  cyc_t                  r_cyc;
  logic [MEM_AW-1:0]     r_addr;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_pending;
  logic [7:0]            r_io [IO_PORTS];

  cyc_dec_t              w_dec;
  logic                  w_bus_idle;
  logic                  w_ram_we;
  logic [MEM_AW-1:0]     w_ram_addr;
  logic [7:0]            w_ram_q;
  logic [IO_AW-1:0]      w_io_idx;
  logic                  w_unused_a;

  assign w_dec      = classify(nM1, nMREQ, nIORQ, nRD, nWR, nRFSH);
  assign w_bus_idle = nMREQ & nIORQ;
  assign w_io_idx   = r_addr[IO_AW-1:0];
  assign w_unused_a = ^A;
  assign nINT       = ~r_pending;

  always_ff @(posedge CLK) begin
    if (!nRESET) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_dec.valid) w_state_nx = (WAIT_STATES > 0) ? WAITST : ACCESS;
      WAITST:  if (r_cnt == WAIT_CNT_W'(1)) w_state_nx = ACCESS;
      ACCESS:  w_state_nx = HOLD;
      HOLD:    if (w_bus_idle) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // RAM reads the live address while idle so the registered read is ready
  // by the ACCESS edge even with zero wait states
  always_comb begin
    w_ram_addr = (r_state == IDLE) ? A[MEM_AW-1:0] : r_addr;
    w_ram_we   = nRESET && (r_state == ACCESS) && (r_cyc == CYC_MWR);
  end

  z80_resp_ram #(.MEM_AW(MEM_AW)) u_ram (
    .clk     (CLK),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (D_in),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_cyc     <= CYC_MRD;
      r_addr    <= '0;
      r_cnt     <= '0;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      nWAIT     <= 1'b1;
      r_pending <= 1'b0;
      for (int k = 0; k < IO_PORTS; k++) r_io[k] <= 8'h00;
    end else begin
      if (int_req) r_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_dec.valid) begin
            r_cyc  <= w_dec.cyc;
            r_addr <= A[MEM_AW-1:0];
            if (WAIT_STATES > 0) begin
              r_cnt <= WAIT_CNT_W'(WAIT_STATES);
              nWAIT <= 1'b0;
            end
          end
        end
        WAITST: begin
          r_cnt <= r_cnt - WAIT_CNT_W'(1);
          if (r_cnt == WAIT_CNT_W'(1)) nWAIT <= 1'b1;
        end
        ACCESS: begin
          case (r_cyc)
            CYC_MRD: begin
              D_out <= w_ram_q;
              D_oe  <= 1'b1;
            end
            CYC_IORD: begin
              D_out <= r_io[w_io_idx];
              D_oe  <= 1'b1;
            end
            CYC_INTA: begin
              D_out <= int_vector;
              D_oe  <= 1'b1;
              if (!int_req) r_pending <= 1'b0;
            end
            CYC_IOWR: r_io[w_io_idx] <= D_in;
            default: ;
          endcase
        end
        HOLD: if (w_bus_idle) D_oe <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < IO_PORTS; k++) begin : g_io_out
    assign io_out[8*k +: 8] = r_io[k];
  end

endmodule

// File: tb/tb_z80_bus_responder_n.sv
// Directed bench for the Z80 bus responder: three instances (1, 0 and 3 wait
// states) share one CPU-side bus driven from a vector table plus sequences.
module tb_z80_bus_responder_n;

  typedef enum int {K_IDLE, K_MRD, K_FETCH, K_MWR, K_IORD, K_IOWR, K_INTA, K_RFSH} kind_t;

  typedef struct {
    kind_t       kind;
    logic [15:0] a;
    logic [7:0]  din;
    logic        exp_oe;
    logic [7:0]  exp_dout;
    int          exp_wait;
    logic [31:0] exp_io;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, int_req;
  logic [15:0] a;
  logic [7:0]  d_in, int_vector;

  logic [7:0]  d_out1, d_out0, d_out3;
  logic        d_oe1, d_oe0, d_oe3;
  logic        n_wait1, n_wait0, n_wait3;
  logic        n_int1, n_int0, n_int3;
  logic [31:0] io_out1, io_out0, io_out3;

  z80_bus_responder_n #(.MEM_AW(12), .IO_PORTS(4), .WAIT_STATES(1)) dut (
    .CLK(clk), .nRESET(n_reset), .A(a), .D_in(d_in), .D_out(d_out1), .D_oe(d_oe1),
    .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh),
    .nWAIT(n_wait1), .nINT(n_int1), .int_req(int_req), .int_vector(int_vector), .io_out(io_out1));

  z80_bus_responder_n #(.MEM_AW(12), .IO_PORTS(4), .WAIT_STATES(0)) dut_ws0 (
    .CLK(clk), .nRESET(n_reset), .A(a), .D_in(d_in), .D_out(d_out0), .D_oe(d_oe0),
    .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh),
    .nWAIT(n_wait0), .nINT(n_int0), .int_req(int_req), .int_vector(int_vector), .io_out(io_out0));

  z80_bus_responder_n #(.MEM_AW(12), .IO_PORTS(4), .WAIT_STATES(3)) dut_ws3 (
    .CLK(clk), .nRESET(n_reset), .A(a), .D_in(d_in), .D_out(d_out3), .D_oe(d_oe3),
    .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh),
    .nWAIT(n_wait3), .nINT(n_int3), .int_req(int_req), .int_vector(int_vector), .io_out(io_out3));

  int checks = 0;
  int errors = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input kind_t k);
    n_m1 = 1'b1; n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_rfsh = 1'b1;
    case (k)
      K_MRD:   begin n_mreq = 1'b0; n_rd = 1'b0; end
      K_FETCH: begin n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0; end
      K_MWR:   begin n_mreq = 1'b0; n_wr = 1'b0; end
      K_IORD:  begin n_iorq = 1'b0; n_rd = 1'b0; end
      K_IOWR:  begin n_iorq = 1'b0; n_wr = 1'b0; end
      K_INTA:  begin n_iorq = 1'b0; n_m1 = 1'b0; end
      K_RFSH:  begin n_mreq = 1'b0; n_rfsh = 1'b0; n_wr = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic run_cycle(input kind_t k, input logic [15:0] addr, input logic [7:0] data);
    a = addr; d_in = data; set_bus(k);
    for (int t = 0; t < 6; t++) tick();
    set_bus(K_IDLE);
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{K_MWR,   16'h0123, 8'h5A, 1'b0, 8'h00, 1, 32'h0000_0000};
    vecs[1]  = '{K_MRD,   16'h0123, 8'h00, 1'b1, 8'h5A, 1, 32'h0000_0000};
    vecs[2]  = '{K_FETCH, 16'h0123, 8'h00, 1'b1, 8'h5A, 1, 32'h0000_0000};
    vecs[3]  = '{K_MWR,   16'h1005, 8'hC3, 1'b0, 8'h00, 1, 32'h0000_0000};
    vecs[4]  = '{K_MRD,   16'h0005, 8'h00, 1'b1, 8'hC3, 1, 32'h0000_0000};
    vecs[5]  = '{K_RFSH,  16'h0005, 8'h00, 1'b0, 8'h00, 0, 32'h0000_0000};
    vecs[6]  = '{K_MRD,   16'h0005, 8'h00, 1'b1, 8'hC3, 1, 32'h0000_0000};
    vecs[7]  = '{K_IOWR,  16'h0002, 8'hA7, 1'b0, 8'h00, 1, 32'h00A7_0000};
    vecs[8]  = '{K_IORD,  16'h0006, 8'h00, 1'b1, 8'hA7, 1, 32'h00A7_0000};
    vecs[9]  = '{K_IOWR,  16'h0101, 8'h3C, 1'b0, 8'h00, 1, 32'h00A7_3C00};
    vecs[10] = '{K_IORD,  16'h0005, 8'h00, 1'b1, 8'h3C, 1, 32'h00A7_3C00};
    vecs[11] = '{K_MWR,   16'hFFFF, 8'h77, 1'b0, 8'h00, 1, 32'h00A7_3C00};
    vecs[12] = '{K_MRD,   16'h0FFF, 8'h00, 1'b1, 8'h77, 1, 32'h00A7_3C00};
    vecs[13] = '{K_IOWR,  16'h0003, 8'hE1, 1'b0, 8'h00, 1, 32'hE1A7_3C00};
    vecs[14] = '{K_IORD,  16'h00FF, 8'h00, 1'b1, 8'hE1, 1, 32'hE1A7_3C00};
    vecs[15] = '{K_MRD,   16'h1123, 8'h00, 1'b1, 8'h5A, 1, 32'hE1A7_3C00};

    n_reset = 1'b0; int_req = 1'b0; int_vector = 8'h00; a = 16'h0000; d_in = 8'h00;
    set_bus(K_IDLE);
    tick();
    tick();
    check("rst_dout",  32'(d_out1),  32'h00);
    check("rst_doe",   32'(d_oe1),   32'h0);
    check("rst_nwait", 32'(n_wait1), 32'h1);
    check("rst_nint",  32'(n_int1),  32'h1);
    check("rst_io",    io_out1,      32'h0);
    n_reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      int w1, w0, w3, lat1, lat0, lat3;
      w1 = 0; w0 = 0; w3 = 0; lat1 = 0; lat0 = 0; lat3 = 0;
      a = vecs[i].a; d_in = vecs[i].din; set_bus(vecs[i].kind);
      for (int t = 1; t <= 7; t++) begin
        tick();
        if (!n_wait1) w1++;
        if (!n_wait0) w0++;
        if (!n_wait3) w3++;
        if (d_oe1 && lat1 == 0) lat1 = t;
        if (d_oe0 && lat0 == 0) lat0 = t;
        if (d_oe3 && lat3 == 0) lat3 = t;
      end
      check($sformatf("v%0d_doe", i), 32'(d_oe1), 32'(vecs[i].exp_oe));
      check($sformatf("v%0d_wait", i), w1, vecs[i].exp_wait);
      check($sformatf("v%0d_io", i), io_out1, vecs[i].exp_io);
      if (vecs[i].exp_oe) begin
        check($sformatf("v%0d_dout", i), 32'(d_out1), 32'(vecs[i].exp_dout));
        check($sformatf("v%0d_lat_ws1", i), lat1, 3);
        check($sformatf("v%0d_lat_ws0", i), lat0, 2);
        check($sformatf("v%0d_lat_ws3", i), lat3, 5);
        check($sformatf("v%0d_wait_ws0", i), w0, 0);
        check($sformatf("v%0d_wait_ws3", i), w3, 3);
        check($sformatf("v%0d_dout_ws3", i), 32'(d_out3), 32'(vecs[i].exp_dout));
      end
      set_bus(K_IDLE);
      tick();
      check($sformatf("v%0d_doe_release", i), 32'(d_oe1), 32'h0);
      tick();
    end

    // interrupt raised, then acknowledged with vector FF
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    check("int_set_nint", 32'(n_int1), 32'h0);
    int_vector = 8'hFF; a = 16'h0038; set_bus(K_INTA);
    tick();
    tick();
    check("inta_pending_before_access", 32'(n_int1), 32'h0);
    tick();
    check("inta_vector", 32'(d_out1), 32'hFF);
    check("inta_doe",    32'(d_oe1),  32'h1);
    check("inta_nint_cleared", 32'(n_int1), 32'h1);
    tick(); tick(); tick();
    set_bus(K_IDLE);
    tick();
    check("inta_doe_release", 32'(d_oe1), 32'h0);
    tick();

    // int_req on the ACCESS edge of an INTA wins over the clear
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    check("int2_set_nint", 32'(n_int1), 32'h0);
    int_vector = 8'h42; set_bus(K_INTA);
    tick();
    tick();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    check("int2_vector", 32'(d_out1), 32'h42);
    check("int2_set_wins", 32'(n_int1), 32'h0);
    tick();
    check("int2_still_pending", 32'(n_int1), 32'h0);
    tick(); tick();
    set_bus(K_IDLE);
    tick(); tick();

    // reset during WAITST of a write leaves RAM untouched
    run_cycle(K_MWR, 16'h0200, 8'h11);
    a = 16'h0200; d_in = 8'h99; set_bus(K_MWR);
    tick();
    check("rstw_waitst_nwait", 32'(n_wait1), 32'h0);
    n_reset = 1'b0; set_bus(K_IDLE);
    tick();
    check("rstw_nwait", 32'(n_wait1), 32'h1);
    check("rstw_doe",   32'(d_oe1),   32'h0);
    check("rstw_nint",  32'(n_int1),  32'h1);
    check("rstw_io",    io_out1,      32'h0);
    n_reset = 1'b1;
    tick();
    a = 16'h0200; set_bus(K_MRD);
    tick(); tick(); tick();
    check("rstw_ram_kept",     32'(d_out1), 32'h11);
    check("rstw_ram_kept_ws0", 32'(d_out0), 32'h11);
    check("rstw_read_doe",     32'(d_oe1),  32'h1);
    set_bus(K_IDLE);
    tick(); tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
